// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// buffers fetched {instr, pc+step} pairs in a DEPTH-entry FIFO ahead of decode.
module if_fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_target,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]    imem_data,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [INSTR_WIDTH-1:0]    id_instr,
  output logic [ADDR_WIDTH-1:0]     id_pc_plus,
  output logic [ADDR_WIDTH-1:0]     pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc_plus;
  } entry_t;

  entry_t                  mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [ADDR_WIDTH-1:0]   pc_seq;
  logic                    deq;
  logic                    enq;

  // Handshake decode; a redirect suppresses both sides for the cycle.
  always_comb begin
    deq    = 1'b0;
    enq    = 1'b0;
    pc_seq = pc + STEP;
    if (!redirect_valid) begin
      deq = id_valid & id_ready;
      enq = fetch_en & ((count < FULL_CNT) | deq);
    end
  end

  assign imem_addr  = pc;
  assign id_valid   = (count != '0);
  assign id_instr   = mem[rd_ptr].instr;
  assign id_pc_plus = mem[rd_ptr].pc_plus;

  // PC, pointers, occupancy and storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= PC_INIT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= '{instr: imem_data, pc_plus: pc_seq};
        wr_ptr      <= wr_ptr + PTR_W'(1);
        pc          <= pc_seq;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios then random traffic, checked against
// a queue-based reference model of the fetch stage.
module tb_if_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;

  logic [31:0] imem_addr, imem_data, id_instr, id_pc_plus, pc;
  logic        id_valid;
  logic [2:0]  count;

  logic [31:0] imem_addr8, imem_data8, id_instr8, id_pc_plus8, pc8;
  logic        id_valid8;
  logic [3:0]  count8;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  always #5 clock = ~clock;

  assign imem_data  = {16'hA5A5, imem_addr[15:0]};
  assign imem_data8 = {16'hA5A5, imem_addr8[15:0]};

  if_fetch_queue dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc_plus(id_pc_plus), .pc(pc), .count(count)
  );

  if_fetch_queue #(.DEPTH(8), .PC_STEP(2), .RESET_PC(32'h100)) dut8 (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr8), .imem_data(imem_data8),
    .id_valid(id_valid8), .id_ready(id_ready), .id_instr(id_instr8),
    .id_pc_plus(id_pc_plus8), .pc(pc8), .count(count8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Compare the default-parameter DUT against the model state.
  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("count", 32'(count), 32'(mq.size()));
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_pc_plus", id_pc_plus, mq[0].pcp);
    end
  endtask

  // Apply one cycle of inputs (called at negedge), advance the model, check at next negedge.
  task automatic step(input logic r, input logic fe, input logic rv,
                      input logic [31:0] tgt, input logic rdy);
    bit d, e;
    reset = r; fetch_en = fe; redirect_valid = rv; redirect_target = tgt; id_ready = rdy;
    if (r) begin
      mq.delete();
      m_pc = 32'h0;
    end else if (rv) begin
      mq.delete();
      m_pc = tgt;
    end else begin
      d = (mq.size() != 0) && rdy;
      e = fe && ((mq.size() < 4) || d);
      if (d) void'(mq.pop_front());
      if (e) begin
        mq.push_back('{instr: {16'hA5A5, m_pc[15:0]}, pcp: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clock);
    check_model();
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; id_ready = 1'b0;
    mq.delete(); m_pc = '0;
    @(negedge clock);

    // Reset state, storage cleared
    step(1, 1, 0, 0, 1);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc_plus", id_pc_plus, 32'h0);
    chk("rst_pc8", pc8, 32'h100);
    chk("rst_count8", 32'(count8), 32'd0);

    // Streaming one instruction per cycle
    step(0, 1, 0, 0, 1);
    chk("s1_valid", 32'(id_valid), 32'd1);
    chk("s1_instr", id_instr, 32'hA5A50000);
    chk("s1_pcp", id_pc_plus, 32'h4);
    chk("s1_pcp8", id_pc_plus8, 32'h102);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    chk("s1_pc", pc, 32'h14);

    // Decode stall: queue fills, PC freezes at 0x10
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
    chk("stall_pc", pc, 32'h10);
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_count8", 32'(count8), 32'd8);

    // Full queue with ready: simultaneous enq/deq, order preserved
    for (int i = 0; i < 4; i++) begin
      chk("full_head", id_instr, 32'hA5A50000 + 32'(4 * i));
      step(0, 1, 0, 0, 1);
      chk("full_count", 32'(count), 32'd4);
    end
    chk("full_pc", pc, 32'h20);

    // Redirect with three entries held
    step(0, 0, 0, 0, 1);
    chk("pre_redir_count", 32'(count), 32'd3);
    step(0, 1, 1, 32'h40, 1);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_pc", pc, 32'h40);
    step(0, 1, 0, 0, 0);
    chk("redir_instr", id_instr, 32'hA5A50040);
    chk("redir_pcp", id_pc_plus, 32'h44);

    // Reset beats redirect; fetch disabled only drains
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h80, 0);
    chk("rst_over_redir", pc, 32'h0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("fe0_pc", pc, 32'h8);
    chk("fe0_count", 32'(count), 32'd0);

    // PC wrap at the top of the address space
    step(0, 1, 1, 32'hFFFFFFFC, 0);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pcp", id_pc_plus, 32'h0);
    chk("wrap_instr", id_instr, 32'hA5A5FFFC);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'hFFFFFFFC);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0), tgt, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
